// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state type and width/limit helpers for the gated frequency meter.
package freq_meter_pkg;

   typedef enum logic {IDLE, MEASURE} state_e;

   function automatic int gcnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

   function automatic logic [63:0] cnt_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: 3-flop synchronizer for an asynchronous input plus rising-edge detect.
module edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic sig_i,
   output logic edge_o
);

   logic [2:0] s_q, s_d;

   assign s_d    = {s_q[1:0], sig_i};
   assign edge_o = s_q[1] & ~s_q[2];

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) s_q <= '0;
      else          s_q <= s_d;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over back-to-back windows of GATE_CYCLES clocks.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   localparam int               GW      = gcnt_width(GATE_CYCLES);
   localparam logic [GW-1:0]    G_LAST  = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

   state_e           state_q, state_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d, freq_q, freq_d, ecnt_inc;
   logic             sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d;
   logic             rise, at_max, sat_inc;

   edge_sync u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .sig_i  (sig_in),
      .edge_o (rise)
   );

   // an edge arriving while the counter is full is dropped and marks the window
   assign at_max   = (ecnt_q == CNT_MAX);
   assign ecnt_inc = (rise && !at_max) ? ecnt_q + 1'b1 : ecnt_q;
   assign sat_inc  = sat_q | (rise & at_max);

   // counters default to clear: covers IDLE, abort and window completion
   always_comb begin
      state_d = state_q;
      gcnt_d  = '0;
      ecnt_d  = '0;
      sat_d   = 1'b0;
      freq_d  = freq_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      if (state_q == IDLE) state_d = en ? MEASURE : IDLE;
      else if (!en) state_d = IDLE;
      else if (gcnt_q == G_LAST) begin
         freq_d  = ecnt_inc;
         ovf_d   = sat_inc;
         valid_d = 1'b1;
      end else begin
         gcnt_d = gcnt_q + 1'b1;
         ecnt_d = ecnt_inc;
         sat_d  = sat_inc;
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         gcnt_q  <= '0;
         ecnt_q  <= '0;
         sat_q   <= 1'b0;
         freq_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         ecnt_q  <= ecnt_d;
         sat_q   <= sat_d;
         freq_q  <= freq_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end

   assign freq  = freq_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;
   assign busy  = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter, 8-bit and 4-bit instances on shared stimulus.
module tb_freq_meter;

   localparam int G = 100;

   typedef struct {
      int f;
      int o;
      int c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic       sig_in = 1'b0;
   logic [7:0] freq8;
   logic [3:0] freq4;
   logic       valid8, ovf8, busy8, valid4, ovf4, busy4;

   exp_t q8[$];
   exp_t q4[$];
   exp_t x8, x4;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   fsum = 0;
   int   last8 = 0;
   int   last4 = 0;
   int   s0;
   logic pat[0:1023];

   freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
      .freq(freq8), .valid(valid8), .ovf(ovf8), .busy(busy8)
   );

   freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
      .freq(freq4), .valid(valid4), .ovf(ovf4), .busy(busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (valid8) begin
         fsum += int'(freq8);
         if (q8.size() == 0) check("valid8_unexpected", 1, 0);
         else begin
            x8 = q8.pop_front();
            check("freq8", int'(freq8), x8.f);
            check("ovf8", int'(ovf8), x8.o);
            check("time8", cyc, x8.c);
         end
      end
      if (valid4) begin
         if (q4.size() == 0) check("valid4_unexpected", 1, 0);
         else begin
            x4 = q4.pop_front();
            check("freq4", int'(freq4), x4.f);
            check("ovf4", int'(ovf4), x4.o);
            check("time4", cyc, x4.c);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill(input int p0, input int p1);
      int p;
      for (int t = 0; t < 1024; t++) begin
         p = (t < G) ? p0 : p1;
         pat[t] = (p != 0) && ((t % p) < (p / 2));
      end
   endtask

   // interval t starts 1 time unit after the posedge where en is raised;
   // a rise first driven in interval t is counted in gate cycle t+1
   task automatic measure(input int n, input int stop_t, input int rst_t);
      int cnt[8];
      int e, wi;
      e = cyc;
      foreach (cnt[w]) cnt[w] = 0;
      for (int t = 0; t < n * G; t++) begin
         wi = (t + 1) / G;
         if (pat[t] && (t == 0 || !pat[t-1]) && wi < n) cnt[wi]++;
      end
      for (int w = 0; w < n; w++)
         if (G * w + G < stop_t && G * w + G < rst_t) begin
            last8 = (cnt[w] > 255) ? 255 : cnt[w];
            last4 = (cnt[w] > 15) ? 15 : cnt[w];
            q8.push_back('{f: last8, o: (cnt[w] > 255) ? 1 : 0, c: e + G + 1 + G * w});
            q4.push_back('{f: last4, o: (cnt[w] > 15) ? 1 : 0, c: e + G + 1 + G * w});
         end
      en = 1'b1;
      for (int t = 0; t < stop_t; t++) begin
         sig_in = pat[t];
         if (t == rst_t) begin
            #3 reset_n = 1'b0;
            #2;
            check("rst_freq8", int'(freq8), 0);
            check("rst_freq4", int'(freq4), 0);
            check("rst_valid", int'(valid8), 0);
            check("rst_ovf", int'(ovf4), 0);
            check("rst_busy", int'(busy8), 0);
            break;
         end
         if (t == 50) begin
            check("busy8_mid", int'(busy8), 1);
            check("busy4_mid", int'(busy4), 1);
         end
         tick(1);
      end
      en = 1'b0;
      sig_in = 1'b0;
      tick(3);
   endtask

   initial begin
      tick(3);
      check("reset_freq", int'(freq8), 0);
      check("reset_valid", int'(valid8), 0);
      check("reset_ovf", int'(ovf8), 0);
      check("reset_busy", int'(busy8), 0);
      reset_n = 1'b1;
      tick(2);
      check("idle_busy", int'(busy8), 0);

      fill(10, 10);
      measure(3, 3 * G + 1, 9999);

      fill(0, 0);
      measure(2, 2 * G + 1, 9999);

      fill(2, 10);
      measure(2, 2 * G + 1, 9999);

      fill(0, 0);
      foreach (pat[t])
         if (t == 10 || t == 50 || t == 98 || t == 100 || t == 198 || t == 240 ||
             t == 298 || t == 302 || t == 398 || t == 450 || t == 498) pat[t] = 1'b1;
      s0 = fsum;
      measure(5, 5 * G + 1, 9999);
      check("edge_sum", fsum - s0, 11);

      fill(10, 10);
      measure(1, G + 1, 9999);
      fill(5, 5);
      measure(1, 51, 9999);
      tick(17);
      check("hold_freq8", int'(freq8), last8);
      check("hold_ovf8", int'(ovf8), 0);
      check("abort_busy", int'(busy8), 0);
      measure(1, G, 9999);
      check("term_abort_freq", int'(freq8), last8);
      measure(1, G + 1, 9999);

      fill(10, 10);
      measure(3, 1000, 250);
      reset_n = 1'b1;
      measure(1, G + 1, 9999);

      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter; the measuring counterpart to the team's fixed-ratio clock dividers (fdiv-style tick generators).
- Counts rising edges of an asynchronous input `sig_in` over a window of `GATE_CYCLES` `clk` cycles.
- Reports each count with a one-cycle valid strobe.
- Used in the VGA/HDMI lab to check divided/pixel-rate signals on-chip and drive a display readout.

Parameters:
- GATE_CYCLES, 1000, window length in `clk` cycles (>=2).
- CNT_W, 16, width of the edge counter and result.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, synchronous enable; high = measure continuously, low = idle.
- sig_in, input, 1, asynchronous signal under measurement.
- freq, output, CNT_W, edges counted in the last completed window; holds between windows.
- valid, output, 1, one-cycle strobe, same cycle `freq`/`ovf` update.
- ovf, output, 1, last completed window saturated.
- busy, output, 1, high while in MEASURE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE.
  - freq=0, valid=0, ovf=0, busy=0.
  - Gate counter, edge counter and synchronizer flops all cleared to 0.
  - Reset mid-window discards that window; no valid is produced.
- Input conditioning: 3 flops s1->s2->s3 from sig_in.
  - edge = s2 & ~s3.
  - A sig_in rise meeting setup is counted 2 cycles later (the cycle edge=1).
  - Pulses shorter than one clk period may be missed; this is by design.
- States:
  - IDLE: busy=0; gcnt=0, ecnt=0. Goes to MEASURE on the cycle after en is sampled high.
  - MEASURE: busy=1. Each cycle gcnt+=1; if edge, ecnt+=1 (saturating, see below).
- Terminal cycle (gcnt==GATE_CYCLES-1, en high), on that posedge:
  - freq <= ecnt + edge (saturated), ovf <= window-saturation flag, valid <= 1.
  - gcnt <= 0, ecnt <= 0, sat flag cleared; stay in MEASURE.
  - Windows are back-to-back with no dead cycles.
  - Every edge is counted in exactly one window; an edge in the terminal cycle belongs to the ending window.
- valid is high for exactly one cycle per completed window; period is exactly GATE_CYCLES while en stays high.
- First valid arrives GATE_CYCLES cycles after MEASURE entry.
- Saturation: ecnt never wraps.
  - At 2^CNT_W-1 further edges are ignored and the window's sat flag is set.
  - freq reports 2^CNT_W-1 with ovf=1.
- en low in MEASURE (any cycle, including the terminal cycle):
  - Next state is IDLE; counters cleared; window aborted; no valid.
  - freq/ovf keep their previous values.
  - en takes priority over terminal-cycle completion.
- en toggled high again: a fresh full window starts; no partial counts carry over.
- freq, ovf, busy and valid are registered outputs, with no combinational path from any input.
- gcnt width is clog2(GATE_CYCLES).

Decomposition:
- Shared package freq_meter_pkg:
  - state enum {IDLE, MEASURE};
  - localparam function for gate counter width;
  - CNT_MAX constant derivation.
- One natural sub-module: edge_sync (3-flop synchronizer + rising-edge detector, reset_n async clear, output edge). Reusable for other async lab inputs.
- FSM, counters and result registers stay in freq_meter.

Test Plan (bench uses GATE_CYCLES=100, CNT_W=8 unless noted):
1. Reset, en=1, sig_in square wave period 10 clk, first rise aligned -> valid every 100 cycles; freq=10 in every window after the first; ovf=0; busy=1.
2. en=1, sig_in held 0 -> freq=0, valid still pulses every 100 cycles.
3. CNT_W=4, sig_in period 2 clk (50 edges/window) -> freq=15, ovf=1. Next window with sig_in period 10 -> freq=10, ovf=0.
4. Edge injected so edge=1 exactly at gcnt==99 -> counted in the ending window, not the next; window sums equal total injected edges over 5 windows.
5. Drop en at gcnt=50, then after 20 cycles raise en -> no valid during the abort; freq holds the prior value; next valid arrives 100 cycles after MEASURE re-entry.
6. Assert reset_n low asynchronously mid-window (between clk edges) -> all outputs 0 immediately; after release with en=1, the first valid arrives after a full 100-cycle window.
